// File: rtl/ahb_config_slave.sv
// ahb_config_slave: AHB register slave holding image-job configuration and a start/busy/done control FSM.
module ahb_config_slave #(
    parameter int BUSWIDTH = 32,
    parameter int ADDR_W   = 8,
    parameter int DIM_W    = 16,
    parameter int FILTER_W = 4
) (
    input  logic                ahb_hclk,
    input  logic                rst,
    input  logic                ahb_hsel,
    input  logic [1:0]          ahb_htrans,
    input  logic                ahb_hwrite,
    input  logic [2:0]          ahb_hsize,
    input  logic [ADDR_W-1:0]   ahb_haddr,
    input  logic [BUSWIDTH-1:0] ahb_hwdata,
    output logic [BUSWIDTH-1:0] ahb_hrdata,
    output logic                ahb_hready,
    output logic                ahb_hresp,
    output logic [DIM_W-1:0]    cfg_width,
    output logic [DIM_W-1:0]    cfg_height,
    output logic [BUSWIDTH-1:0] cfg_read_addr,
    output logic [BUSWIDTH-1:0] cfg_write_addr,
    output logic [FILTER_W-1:0] cfg_filter,
    output logic                start,
    input  logic                done_in,
    output logic                busy,
    output logic                irq
);
    typedef enum logic [1:0] {IDLE, KICK, BUSY} state_t;

    localparam logic [ADDR_W-1:0] A_DIM    = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_RADDR  = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_WADDR  = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_FILTER = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h14);

    state_t                state_q, state_d;
    logic                  dp_valid_q, dp_write_q, err2_q;
    logic [2:0]            dp_size_q;
    logic [ADDR_W-1:0]     dp_addr_q;
    logic [DIM_W-1:0]      width_q, height_q;
    logic [BUSWIDTH-1:0]   raddr_q, waddr_q, rdata;
    logic [FILTER_W-1:0]   filter_q;
    logic                  irq_en_q, irq_en_d, done_q, done_d, irq_q;
    logic                  s_dim, s_raddr, s_waddr, s_filter, s_ctrl, s_status;
    logic                  cfg_sel, start_req, bad, err_now, wr_ok;
    logic                  unused;

    assign unused    = ahb_htrans[0];
    assign s_dim     = dp_addr_q == A_DIM;
    assign s_raddr   = dp_addr_q == A_RADDR;
    assign s_waddr   = dp_addr_q == A_WADDR;
    assign s_filter  = dp_addr_q == A_FILTER;
    assign s_ctrl    = dp_addr_q == A_CTRL;
    assign s_status  = dp_addr_q == A_STATUS;
    assign cfg_sel   = s_dim | s_raddr | s_waddr | s_filter | s_ctrl;
    assign start_req = s_ctrl & ahb_hwdata[0];
    // busy is the registered state, so a done_in landing in this data phase cannot rescue a write
    assign bad = !(cfg_sel | s_status) | (dp_size_q != 3'b010) | (dp_write_q & cfg_sel & busy)
               | (dp_write_q & start_req & (width_q == '0 | height_q == '0));
    assign err_now = dp_valid_q & bad;
    assign wr_ok   = dp_valid_q & dp_write_q & !bad;

    assign ahb_hready     = !err_now;
    assign ahb_hresp      = err_now | err2_q;
    assign ahb_hrdata     = rdata;
    assign busy           = state_q != IDLE;
    assign start          = state_q == KICK;
    assign irq            = irq_q;
    assign cfg_width      = width_q;
    assign cfg_height     = height_q;
    assign cfg_read_addr  = raddr_q;
    assign cfg_write_addr = waddr_q;
    assign cfg_filter     = filter_q;

    always_comb begin
        rdata = '0;
        if (dp_valid_q && !dp_write_q && !bad) begin
            if (s_dim) begin
                rdata[DIM_W-1:0]  = width_q;
                rdata[16 +: DIM_W] = height_q;
            end
            if (s_raddr) rdata = raddr_q;
            if (s_waddr) rdata = waddr_q;
            if (s_filter) rdata[FILTER_W-1:0] = filter_q;
            if (s_ctrl) rdata[1] = irq_en_q;
            if (s_status) rdata[1:0] = {done_q, busy};
        end
    end

    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        irq_en_d = (wr_ok & s_ctrl) ? ahb_hwdata[1] : irq_en_q;
        if (wr_ok & s_status & ahb_hwdata[1]) done_d = 1'b0;
        case (state_q)
            IDLE: if (wr_ok & start_req) begin
                state_d = KICK;
                done_d  = 1'b0;
            end
            KICK: state_d = BUSY;
            BUSY: if (done_in) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ahb_hclk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge ahb_hclk) begin
        if (rst) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_size_q  <= '0;
            dp_addr_q  <= '0;
            err2_q     <= 1'b0;
            width_q    <= '0;
            height_q   <= '0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            filter_q   <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            dp_valid_q <= ahb_hsel & ahb_htrans[1] & ahb_hready;
            dp_write_q <= ahb_hwrite;
            dp_size_q  <= ahb_hsize;
            dp_addr_q  <= ahb_haddr;
            err2_q     <= err_now;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            irq_q      <= done_d & irq_en_d;
            if (wr_ok & s_dim) begin
                width_q  <= ahb_hwdata[DIM_W-1:0];
                height_q <= ahb_hwdata[16 +: DIM_W];
            end
            if (wr_ok & s_raddr) raddr_q <= ahb_hwdata;
            if (wr_ok & s_waddr) waddr_q <= ahb_hwdata;
            if (wr_ok & s_filter) filter_q <= ahb_hwdata[FILTER_W-1:0];
        end
    end
endmodule

// File: doc/ahb_config_slave.md
AHB_CONFIG_SLAVE -- requirements
Module: ahb_config_slave

Interface
REQ-001 SHALL have parameter BUSWIDTH, default 32: AHB data and address-register width.
REQ-002 SHALL have parameter ADDR_W, default 8: decoded low bits of ahb_haddr.
REQ-003 SHALL have parameter DIM_W, default 16: image width and height field width (DIM_W <= BUSWIDTH/2).
REQ-004 SHALL have parameter FILTER_W, default 4: filter-mode field width.
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports as listed below:
- ahb_hclk  in  1  bus clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- ahb_hsel  in  1  slave select.
- ahb_htrans  in  2  transfer kind; bit1=1 means NONSEQ/SEQ.
- ahb_hwrite  in  1  1=write.
- ahb_hsize  in  3  transfer size.
- ahb_haddr  in  ADDR_W  byte offset.
- ahb_hwdata  in  BUSWIDTH  write data.
- ahb_hrdata  out  BUSWIDTH  read data.
- ahb_hready  out  1  transfer complete / slave ready.
- ahb_hresp  out  1  0=OKAY, 1=ERROR.
- cfg_width, cfg_height  out  DIM_W each  image dimensions.
- cfg_read_addr, cfg_write_addr  out  BUSWIDTH each  image source/destination base addresses.
- cfg_filter  out  FILTER_W  filter mode.
- start  out  1  one-cycle kickstart pulse to controllers.
- done_in  in  1  controllers finished (single-cycle pulse).
- busy  out  1  job in progress.
- irq  out  1  level interrupt.

Function
REQ-006 SHALL accept an address phase when ahb_hsel=1, ahb_htrans[1]=1 and ahb_hready=1, registering offset, direction and size.
REQ-007 SHALL use this register map:
- 0x00 DIM: [DIM_W-1:0]=width, [16+DIM_W-1:16]=height.
- 0x04 RADDR.
- 0x08 WADDR.
- 0x0C FILTER: [FILTER_W-1:0].
- 0x10 CTRL: bit0=start (write-only, reads 0), bit1=irq_en.
- 0x14 STATUS: bit0=busy, bit1=done; writing 1 to bit1 clears done.
REQ-008 SHALL complete OKAY transfers in the data phase with zero wait states; write data SHALL update the register at the end of that cycle.
REQ-009 SHALL drive ahb_hrdata during a read data phase from the registered offset; unused bits SHALL read 0; ahb_hrdata SHALL be 0 outside read data phases.
REQ-010 SHALL give an ERROR response for any of the following, leaving all registers unchanged:
- unmapped offset;
- ahb_hsize != 3'b010;
- offset[1:0] != 0;
- write to DIM, RADDR, WADDR, FILTER or CTRL while busy=1;
- CTRL start write with width==0 or height==0.
REQ-011 ERROR response SHALL take two cycles: cycle 1 ahb_hready=0, ahb_hresp=1; cycle 2 ahb_hready=1, ahb_hresp=1. An address phase presented in cycle 1 SHALL be ignored.
REQ-012 Control FSM SHALL have three states:
- IDLE -> KICK on an accepted CTRL write with bit0=1.
- KICK -> BUSY after one cycle; start=1 only in KICK.
- BUSY -> IDLE on done_in=1, setting done=1.
REQ-013 busy SHALL be 1 in KICK and BUSY; done_in SHALL be ignored in IDLE and KICK.
REQ-014 A new start from IDLE SHALL clear done.
REQ-015 If done_in arrives in the same cycle as a write data phase that would otherwise be rejected for busy, that write SHALL still be rejected with ERROR: busy is evaluated at the start of the data phase.
REQ-016 irq SHALL equal done AND irq_en, registered.
REQ-017 A CTRL write SHALL update irq_en even when bit0=0.
REQ-018 cfg_* outputs SHALL reflect the register contents directly and SHALL be stable while busy=1.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL reset to the following values:
- all registers, cfg_* outputs, start, busy, done, irq and ahb_hrdata: 0;
- ahb_hready: 1;
- ahb_hresp: 0;
- FSM: IDLE.
REQ-020 Reset SHALL override everything, including mid-ERROR response and BUSY; no start pulse SHALL follow reset.

Verification
REQ-021 Write DIM=0x00F0_0140, RADDR=0x1000, WADDR=0x8000, FILTER=0x3, then read each back -> identical values with OKAY and zero wait states; cfg_width=0x140, cfg_height=0xF0.
REQ-022 Write CTRL=0x3 with valid dimensions -> start=1 for exactly one cycle, then busy=1; pulse done_in -> busy=0, STATUS=0x2, irq=1; write STATUS=0x2 -> irq=0.
REQ-023 While busy, write RADDR=0xDEAD -> two-cycle ERROR (hready 0 then 1, hresp 1 both cycles), RADDR unchanged; same for a CTRL start write.
REQ-024 Invalid accesses -> ERROR and no state change: CTRL start with DIM=0; access to offset 0x18; byte-size (hsize=0) write; offset 0x02.
REQ-025 Assert rst during BUSY and during ERROR cycle 1 -> next cycle all outputs at reset values, hready=1, no start pulse.
REQ-026 done_in coincident with the data phase of a RADDR write issued while busy -> write rejected with ERROR, FSM reaches IDLE with done=1.
